// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipe: load-use stalls, redirect flushes,
// memory freeze and saturating stall/flush statistics.
module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] LSTALL = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;
    localparam logic [1:0] LS_REM = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [1:0] FL_REM = 2'(FLUSH_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use, redirect;

    assign load_use = idex_mem_read && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    assign redirect = branch_taken || jump;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (mem_busy) begin
            state_d = state_q;
            rem_d   = rem_q;
        end else if (redirect) begin
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                rem_d   = FL_REM;
            end else begin
                state_d = RUN;
                rem_d   = 2'd0;
            end
        end else begin
            case (state_q)
                LSTALL, FLUSH: begin
                    if (rem_q <= 2'd1) begin
                        state_d = RUN;
                        rem_d   = 2'd0;
                    end else begin
                        rem_d   = rem_q - 2'd1;
                    end
                end
                // RUN and the unencoded state 3 behave identically
                default: begin
                    if (load_use && (LOAD_STALL_CYCLES > 1)) begin
                        state_d = LSTALL;
                        rem_d   = LS_REM;
                    end else begin
                        state_d = RUN;
                        rem_d   = 2'd0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!reset_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (redirect) begin
            ifid_flush  = 1'b1;
        end else begin
            case (state_q)
                LSTALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
                FLUSH: ifid_flush = 1'b1;
                default: begin
                    if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else if (!mem_busy) begin
            if (idex_bubble && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
            if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: a default-parameter instance driven from a vector table and
// an alternate instance (3-cycle stall, 2-cycle flush, 4-bit counters) for multi-cycle cases.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       reset_n;
    logic       idex_mem_read;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       ifid_uses_rt, branch_taken, jump, mem_busy, cnt_clr;

    logic        d_pc, d_iw, d_fl, d_bb;
    logic [1:0]  d_st;
    logic [15:0] d_sc, d_fc;
    logic        a_pc, a_iw, a_fl, a_bb;
    logic [1:0]  a_st;
    logic [3:0]  a_sc, a_fc;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_hazard_ctrl u_def (
        .clk(clk), .reset_n(reset_n), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .jump(jump), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
        .pc_write(d_pc), .ifid_write(d_iw), .ifid_flush(d_fl), .idex_bubble(d_bb),
        .state(d_st), .stall_cnt(d_sc), .flush_cnt(d_fc)
    );

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_alt (
        .clk(clk), .reset_n(reset_n), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .jump(jump), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
        .pc_write(a_pc), .ifid_write(a_iw), .ifid_flush(a_fl), .idex_bubble(a_bb),
        .state(a_st), .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        mr;
        logic [4:0]  irt, rs, rt;
        logic        urt, br, jp, busy, clr;
        logic        pc, iw, fl, bb;
        logic [1:0]  st;
        logic [15:0] sc, fc;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(int mr, int irt, int rs, int rt, int urt, int br, int jp,
                                int busy, int clr, int pc, int iw, int fl, int bb,
                                int st, int sc, int fc);
        vec_t v;
        v.mr = 1'(mr); v.irt = 5'(irt); v.rs = 5'(rs); v.rt = 5'(rt);
        v.urt = 1'(urt); v.br = 1'(br); v.jp = 1'(jp); v.busy = 1'(busy); v.clr = 1'(clr);
        v.pc = 1'(pc); v.iw = 1'(iw); v.fl = 1'(fl); v.bb = 1'(bb);
        v.st = 2'(st); v.sc = 16'(sc); v.fc = 16'(fc);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_o(input bit alt, input string nm, input logic pc, input logic iw,
                         input logic fl, input logic bb, input logic [1:0] st);
        logic [5:0] act;
        act = alt ? {a_pc, a_iw, a_fl, a_bb, a_st} : {d_pc, d_iw, d_fl, d_bb, d_st};
        chk({nm, " pc/iw/fl/bb/st"}, 32'(act), 32'({pc, iw, fl, bb, st}));
    endtask

    task automatic idle();
        idex_mem_read = 1'b0; idex_rt = 5'd8; ifid_rs = 5'd8; ifid_rt = 5'd0;
        ifid_uses_rt = 1'b0; branch_taken = 1'b0; jump = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        //          mr irt rs rt urt br jp bsy clr | pc iw fl bb st sc fc
        tbl[0]  = mk(0, 8, 8, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 8, 8, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(0, 8, 8, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1, 0);
        tbl[3]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1, 0);
        tbl[4]  = mk(1, 8, 3, 8, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1, 0);
        tbl[5]  = mk(1, 8, 3, 8, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0);
        tbl[6]  = mk(1, 8, 8, 0, 0, 1, 0, 0, 0,  1, 1, 1, 0, 0, 2, 0);
        tbl[7]  = mk(0, 8, 8, 0, 0, 0, 1, 0, 0,  1, 1, 1, 0, 0, 2, 1);
        tbl[8]  = mk(1, 8, 8, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 2, 2);
        tbl[9]  = mk(0, 8, 8, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 2, 2);
        tbl[10] = mk(0, 8, 8, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2, 2);
        tbl[11] = mk(0, 8, 8, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 2, 2);
        tbl[12] = mk(0, 8, 8, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);

        reset_n = 1'b0;
        idle();
        #3;
        chk_o(0, "reset_def", 0, 0, 1, 1, 0);
        chk("reset_stall_cnt", 32'(d_sc), 32'd0);
        chk("reset_flush_cnt", 32'(d_fc), 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            idex_mem_read = tbl[i].mr; idex_rt = tbl[i].irt; ifid_rs = tbl[i].rs;
            ifid_rt = tbl[i].rt; ifid_uses_rt = tbl[i].urt; branch_taken = tbl[i].br;
            jump = tbl[i].jp; mem_busy = tbl[i].busy; cnt_clr = tbl[i].clr;
            #2;
            chk_o(0, $sformatf("vec%0d", i), tbl[i].pc, tbl[i].iw, tbl[i].fl, tbl[i].bb, tbl[i].st);
            chk($sformatf("vec%0d stall_cnt", i), 32'(d_sc), 32'(tbl[i].sc));
            chk($sformatf("vec%0d flush_cnt", i), 32'(d_fc), 32'(tbl[i].fc));
            @(negedge clk);
        end

        // two-cycle flush on a single jump
        do_reset(); idle(); jump = 1'b1;
        #2 chk_o(1, "jmp_c0", 1, 1, 1, 0, 0);
        @(negedge clk); jump = 1'b0;
        #2 chk_o(1, "jmp_c1", 1, 1, 1, 0, 2);
        @(negedge clk);
        #2 chk_o(1, "jmp_c2", 1, 1, 0, 0, 0);
        chk("jmp flush_cnt", 32'(a_fc), 32'd2);

        // three-cycle load stall frozen by mem_busy in the middle
        @(negedge clk);
        do_reset(); idle(); idex_mem_read = 1'b1;
        #2 chk_o(1, "ls_c0", 0, 0, 0, 1, 0);
        @(negedge clk); idex_mem_read = 1'b0; mem_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2 chk_o(1, $sformatf("ls_frz%0d", k), 0, 0, 0, 0, 1);
            chk($sformatf("ls_frz%0d stall_cnt", k), 32'(a_sc), 32'd1);
            @(negedge clk);
        end
        mem_busy = 1'b0;
        #2 chk_o(1, "ls_c1", 0, 0, 0, 1, 1);
        @(negedge clk);
        #2 chk_o(1, "ls_c2", 0, 0, 0, 1, 1);
        @(negedge clk);
        #2 chk_o(1, "ls_done", 1, 1, 0, 0, 0);
        chk("ls stall_cnt", 32'(a_sc), 32'd3);

        // saturation of the 4-bit counter, then clear
        @(negedge clk); idex_mem_read = 1'b1;
        repeat (20) @(negedge clk);
        idex_mem_read = 1'b0;
        #2 chk("sat stall_cnt", 32'(a_sc), 32'd15);
        chk_o(1, "sat_tail", 0, 0, 0, 1, 1);
        cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        #2 chk("clr stall_cnt", 32'(a_sc), 32'd0);
        chk_o(1, "clr_run", 1, 1, 0, 0, 0);

        // asynchronous reset in the middle of a load stall
        @(negedge clk); idex_mem_read = 1'b1;
        @(negedge clk); idex_mem_read = 1'b0;
        #2 chk_o(1, "rst_pre", 0, 0, 0, 1, 1);
        reset_n = 1'b0;
        #1 chk_o(1, "rst_mid", 0, 0, 1, 1, 0);
        chk("rst_mid stall_cnt", 32'(a_sc), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        #2 chk_o(1, "rst_after", 1, 1, 0, 0, 0);
        @(negedge clk);
        #2 chk_o(1, "rst_after2", 1, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
